// File: rtl/arith_op_sequencer.sv
// Requester-side driver for the 5-operand / 4-mode arithmetic unit: latches one operand set,
// walks op_mode through the enabled modes capturing op_y, then returns all slots as one response.
module arith_op_sequencer #(
  parameter int unsigned OPW       = 3,
  parameter int unsigned RW        = 8,
  parameter logic [3:0]  MODE_MASK = 4'b1111
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [OPW-1:0]  req_a,
  input  logic [OPW-1:0]  req_b,
  input  logic [OPW-1:0]  req_c,
  input  logic [OPW-1:0]  req_d,
  input  logic [OPW-1:0]  req_e,
  output logic [OPW-1:0]  op_a,
  output logic [OPW-1:0]  op_b,
  output logic [OPW-1:0]  op_c,
  output logic [OPW-1:0]  op_d,
  output logic [OPW-1:0]  op_e,
  output logic [1:0]      op_mode,
  input  logic [RW-1:0]   op_y,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [4*RW-1:0] rsp_data,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t     state, state_d;
  logic       accept;
  logic       first_en, nxt_en;
  logic [1:0] first_mode, nxt_mode;

  // Lowest enabled mode, and the next enabled mode above the one currently issued.
  always_comb begin
    first_en   = 1'b0;
    first_mode = '0;
    nxt_en     = 1'b0;
    nxt_mode   = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (MODE_MASK[k] && !first_en) begin
        first_en   = 1'b1;
        first_mode = 2'(k);
      end
      if (MODE_MASK[k] && (k > 32'(op_mode)) && !nxt_en) begin
        nxt_en   = 1'b1;
        nxt_mode = 2'(k);
      end
    end
  end

  // req_ready is held low while reset is asserted so every output reads 0 during reset.
  always_comb begin
    state_d   = state;
    req_ready = rst_n && (state == IDLE);
    rsp_valid = (state == DONE);
    busy      = (state != IDLE);
    accept    = req_valid && req_ready;
    unique case (state)
      IDLE:    if (accept) state_d = first_en ? ISSUE : DONE;
      ISSUE:   if (!nxt_en) state_d = DONE;
      DONE:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a     <= '0;
      op_b     <= '0;
      op_c     <= '0;
      op_d     <= '0;
      op_e     <= '0;
      op_mode  <= '0;
      rsp_data <= '0;
    end else if (accept) begin
      op_a     <= req_a;
      op_b     <= req_b;
      op_c     <= req_c;
      op_d     <= req_d;
      op_e     <= req_e;
      rsp_data <= '0;
      if (first_en) op_mode <= first_mode;
    end else if (state == ISSUE) begin
      rsp_data[32'(op_mode)*RW +: RW] <= op_y;
      if (nxt_en) op_mode <= nxt_mode;
    end
  end

endmodule
